// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT accelerator control path.
package ntt_pkg;

    typedef enum logic [1:0] {
        OP_NTT   = 2'd0,
        OP_INTT  = 2'd1,
        OP_PWM   = 2'd2,
        OP_CLEAR = 2'd3
    } ntt_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_WAIT_RUN = 3'd2,
        ST_RUN      = 3'd3,
        ST_PAIR     = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_DONE     = 3'd6
    } ntt_seq_state_e;

    localparam int NTT_SEQ_CYCLES_W = 16;

    // Saturating increment used by the optional op cycle counter.
    function automatic logic [NTT_SEQ_CYCLES_W-1:0] sat_inc(input logic [NTT_SEQ_CYCLES_W-1:0] v);
        logic [NTT_SEQ_CYCLES_W-1:0] r;
        if (v == {NTT_SEQ_CYCLES_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(NTT_SEQ_CYCLES_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // PWM and CLEAR use the sequencer's own pair stream instead of the address unit.
    function automatic logic is_pointwise(input ntt_op_e op);
        return (op == OP_PWM) || (op == OP_CLEAR);
    endfunction

endpackage

// File: rtl/ntt_seq_pair_gen.sv
// Pair counter for pointwise/clear passes: emits (2i, 2i+1) for i = 0..N/2-1
// and holds at the terminal pair instead of wrapping.
module ntt_seq_pair_gen #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  active_i,
    output logic                  last_o,
    output logic [ADDR_WIDTH-1:0] raddr1_o,
    output logic [ADDR_WIDTH-1:0] raddr2_o
);

    localparam int PW = ADDR_WIDTH - 1;

    logic [PW-1:0] idx_q;
    logic [PW-1:0] idx_d;

    // Next pair index: restart on a new op, advance while active, stop at the end.
    always_comb begin
        idx_d = idx_q;
        if (start_i) begin
            idx_d = '0;
        end else if (active_i && !last_o) begin
            idx_d = idx_q + PW'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    // Pair index register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign last_o   = (idx_q == {PW{1'b1}});
    assign raddr1_o = active_i ? {idx_q, 1'b0} : '0;
    assign raddr2_o = active_i ? {idx_q, 1'b1} : '0;

endmodule

// File: rtl/ntt_sequencer.sv
// Command-level controller for the NTT accelerator: launches the butterfly
// address unit, generates pointwise/clear pairs, drains, and arbitrates the
// host memory port. Optional op cycle counter: define NTT_SEQ_CYCLE_COUNT_EN.
module ntt_sequencer
    import ntt_pkg::*;
#(
    parameter int ADDR_WIDTH    = 6,
    parameter int BF_LATENCY    = 3,
    parameter int START_TIMEOUT = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [1:0]                  cmd_op_i,
    output logic                        done_o,
    output logic                        err_o,
    output logic                        busy_o,
    output logic                        ntt_start_o,
    input  logic                        run_loop_i,
    output logic                        inverse_o,
    output logic                        single_bf_o,
    output logic                        clr_o,
    output logic [ADDR_WIDTH-1:0]       pw_raddr1_o,
    output logic [ADDR_WIDTH-1:0]       pw_raddr2_o,
    input  logic                        host_req_i,
    output logic                        host_gnt_o,
    output logic [NTT_SEQ_CYCLES_W-1:0] cycles_o
);

    localparam int TMR_W = $clog2(START_TIMEOUT + 1);
    localparam int DRN_W = (BF_LATENCY > 1) ? $clog2(BF_LATENCY + 1) : 1;

    ntt_seq_state_e     state_q, state_d;
    ntt_op_e            op_q, op_d;
    logic               err_q, err_d;
    logic               armed_q, armed_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [DRN_W-1:0]   drain_q, drain_d;

    logic               accept_s;
    logic               idle_s;
    logic               pair_active_s;
    logic               pair_last_s;

    // armed_q keeps the IDLE handshake outputs at zero for the first cycle after reset.
    assign idle_s        = (state_q == ST_IDLE);
    assign accept_s      = idle_s && armed_q && cmd_valid_i && !host_req_i;
    assign pair_active_s = (state_q == ST_PAIR);
    assign armed_d       = 1'b1;

    // Next-state, op latch, start timer and drain counter.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        timer_d = timer_q;
        drain_d = '0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (accept_s) begin
                    op_d  = ntt_op_e'(cmd_op_i);
                    err_d = 1'b0;
                    if (is_pointwise(ntt_op_e'(cmd_op_i))) begin
                        state_d = ST_PAIR;
                    end else begin
                        state_d = ST_START;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                timer_d = timer_q + TMR_W'(1);
                state_d = ST_WAIT_RUN;
            end
            ST_WAIT_RUN: begin
                if (run_loop_i) begin
                    state_d = ST_RUN;
                end else if (timer_q == TMR_W'(START_TIMEOUT)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RUN: begin
                if (!run_loop_i) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAIR: begin
                if (pair_last_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_PAIR;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRN_W'(BF_LATENCY - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NTT;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
            timer_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
            armed_q <= armed_d;
            timer_q <= timer_d;
            drain_q <= drain_d;
        end
    end

    ntt_seq_pair_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pair_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept_s),
        .active_i (pair_active_s),
        .last_o   (pair_last_s),
        .raddr1_o (pw_raddr1_o),
        .raddr2_o (pw_raddr2_o)
    );

    assign cmd_ready_o = idle_s && armed_q && !host_req_i;
    assign host_gnt_o  = idle_s && armed_q && host_req_i;
    assign busy_o      = !idle_s;
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = done_o && err_q;
    assign ntt_start_o = (state_q == ST_START);
    assign inverse_o   = busy_o && (op_q == OP_INTT);
    assign single_bf_o = pair_active_s;
    assign clr_o       = pair_active_s && (op_q == OP_CLEAR);

`ifdef NTT_SEQ_CYCLE_COUNT_EN
    logic [NTT_SEQ_CYCLES_W-1:0] cnt_q, cnt_d;
    logic [NTT_SEQ_CYCLES_W-1:0] cycles_q, cycles_d;

    // Busy-cycle count; the published value includes the DONE cycle itself.
    always_comb begin
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        if (accept_s) begin
            cnt_d = '0;
        end else if (busy_o) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            cycles_d = sat_inc(cnt_d);
        end else begin
            cycles_d = cycles_q;
        end
    end

    // Cycle counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
        end
    end

    assign cycles_o = cycles_q;
`else
    assign cycles_o = '0;
`endif

endmodule
